// File: rtl/mul_pkg.sv
// Shared constants and types for the sequential shift-add multiplier.
//   MUL_W    : operand width (fixed by the 8-bit ripple adder)
//   CNT_W    : iteration counter width
//   MUL_LAST : counter value of the final iteration
//   state_t  : FSM state encoding
package mul_pkg;
  localparam int MUL_W = 8;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] MUL_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/mul_shift_add_8_if.sv
// Handshake/data bundle between a requester and mul_shift_add_8.
//   start   : request, sampled on the rising clock edge
//   a, b    : multiplicand / multiplier, captured on acceptance
//   busy    : high while iterating
//   done    : one-cycle pulse when product updates
//   product : 16-bit unsigned result, held until the next completion
// master = requester side, slave = multiplier side.
interface mul_shift_add_8_if;
  import mul_pkg::*;

  logic               start;
  logic [MUL_W-1:0]   a;
  logic [MUL_W-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*MUL_W-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/add_rca_8.sv
// 8-bit ripple-carry adder.
//   a, b  : addends
//   c_in  : carry into bit 0
//   sum   : 8-bit sum
//   c_out : carry out of bit 7
module add_rca_8
  import mul_pkg::*;
(
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  input  logic             c_in,
  output logic [MUL_W-1:0] sum,
  output logic             c_out
);
  logic [MUL_W:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < MUL_W; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[MUL_W];
endmodule

// File: rtl/mul_shift_add_8.sv
// Sequential 8x8 unsigned shift-add multiplier, one partial product per
// clock through add_rca_8. Accepted request yields a product after 8
// iterations; done pulses for one cycle as product updates.
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : start/a/b in, busy/done/product out (slave modport)
module mul_shift_add_8
  import mul_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  mul_shift_add_8_if.slave    bus
);
  state_t               state;
  logic [MUL_W-1:0]     mcand;
  logic [MUL_W-1:0]     hi;
  logic [MUL_W-1:0]     lo;
  logic [CNT_W-1:0]     cnt;
  logic [2*MUL_W-1:0]   product;

  logic [MUL_W-1:0]     sum;
  logic                 c_out;
  logic [2*MUL_W-1:0]   acc_nxt;

  add_rca_8 u_add (
    .a     (hi),
    .b     (mcand),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // Multiplier bit lo[0] selects add-then-shift or plain shift; the adder
  // carry becomes the top bit of the shifted accumulator.
  always_comb begin
    acc_nxt = {1'b0, hi, lo[MUL_W-1:1]};
    if (lo[0]) acc_nxt = {c_out, sum, lo[MUL_W-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand <= bus.a;
            hi    <= '0;
            lo    <= bus.b;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          {hi, lo} <= acc_nxt;
          cnt      <= cnt + 3'd1;
          if (cnt == MUL_LAST) begin
            product <= acc_nxt;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product;
endmodule
